fpu_fminmax_issue: RTL and testbench
====================================

// Module: fpu_fminmax_issue
// PURPOSE
//  Issue/result stage that wraps the combinational fpu_fminmax core for fmin.s/fmax.s.
//  - Buffers operand requests in a small FIFO behind a valid/ready handshake.
//  - Pre-screens NaNs with RISC-V F semantics, which the core does not handle.
//  - Registers the result, tag and fflags for the FPU writeback arbiter downstream.
// PARAMETERS
//  DEPTH  2  operand FIFO entries; power of two, >=2
//  TAG_W  5  width of destination tag carried alongside each op (rd index)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  rst           in   1      synchronous reset, active-high
//  flush         in   1      synchronous pipeline flush (exception/redirect)
//  in_valid      in   1      request valid
//  in_ready      out  1      request accepted when in_valid&in_ready
//  in_rs1        in   32     FP32 operand 1
//  in_rs2        in   32     FP32 operand 2
//  in_min0_max1  in   1      0: fmin.s, 1: fmax.s
//  in_tag        in   TAG_W  destination tag
//  out_valid     out  1      result valid
//  out_ready     in   1      downstream accepts when out_valid&out_ready
//  out_result    out  32     FP32 result
//  out_tag       out  TAG_W  tag of result
//  out_fflags    out  5      {NV,DZ,OF,UF,NX}; only NV is ever set
// BEHAVIOUR
//  Reset (rst=1 at an edge)
//  - FIFO emptied; out_valid=0, out_result=0, out_tag=0, out_fflags=0.
//  - in_ready=0 during the reset cycle and 1 on the first cycle after.
//  Input
//  - in_ready = !fifo_full & !flush & !rst. It is registered-state only, with no path from out_ready.
//  - When full, no enqueue occurs even if a dequeue happens in the same cycle.
//  FIFO
//  - Count is $clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
//  - Simultaneous enq+deq leaves the count unchanged.
//  - Dequeue at most 1 and enqueue at most 1 per cycle.
//  Head evaluation (combinational on FIFO head)
//  - isnan = exp==8'hFF & man!=0; issnan = isnan & ~man[22].
//  - Both NaN -> 32'h7FC00000 (canonical NaN).
//  - Exactly one NaN -> the other operand, bit-exact.
//  - Neither NaN -> fpu_fminmax rd, including -0 < +0 ordering.
//  - Examples: fmin(+0,-0)=32'h80000000; fmax(+0,-0)=32'h00000000.
//  - NV=1 iff either operand is an sNaN; a qNaN alone gives NV=0.
//  Output register
//  - Loads head result when FIFO non-empty & (!out_valid | out_ready); this dequeues the head.
//  - While out_valid & !out_ready: out_result, out_tag and out_fflags hold stable.
//  - When out_valid=0, payload holds its last value; it is not cleared.
//  - Latency: accepted at edge k -> out_valid from edge k+1.
//  - Throughput: 1 op/cycle with out_ready=1.
//  Flush
//  - Same edge empties the FIFO and clears out_valid; any accept in that cycle is dropped.
//  - rst has priority over flush; otherwise identical effect, plus the payload is zeroed.
//  - Mid-operation reset or flush discards everything in flight; no partial result is emitted.
// STRUCTURE
//  fpu_pkg (shared)
//  - typedef fp32_t = struct packed {sign, exp[7:0], man[22:0]}
//  - typedef fflags_t = logic[4:0]
//  - localparams FP32_CANON_NAN=32'h7FC00000, FFLAG_NV=4
//  - function fp32_is_nan, function fp32_is_snan
//  Sub-module: fpu_fminmax (existing core), one instance fed by the FIFO head.
//  FIFO and output register are inline in this module.
// TESTING
//  - fmin 1.0(3F800000), 2.0(40000000) -> out_result=3F800000, NV=0, 2nd edge after accept.
//  - fmax qNaN 7FC00001, -3.0(C0400000) -> C0400000, NV=0.
//  - fmin sNaN 7F800001, sNaN FF800001 -> 7FC00000, NV=1.
//  - fmin 00000000, 80000000 -> 80000000; fmax of the same pair -> 00000000.
//  - Hold out_ready=0 and push DEPTH+1 ops: after edge k+1, 1 result in the output register.
//    - in_ready stays 1 until DEPTH more ops fill the FIFO, then drops to 0.
//    - out_* stays stable throughout.
//    - Release out_ready: results emerge in order with tags 0,1,2, 1/cycle.
//  - Full pipe, assert flush for 1 cycle -> out_valid=0 next cycle.
//    - in_ready=1 the cycle after; no stale result ever appears.
//    - Repeat the same sequence with rst: payload also reads 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP32 types, constants and NaN classification helpers for the FPU
// issue and execute blocks.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef logic [4:0] fflags_t;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;
  localparam int          FFLAG_NV       = 4;

  function automatic logic fp32_is_nan(input fp32_t x);
    return (x.exp == 8'hFF) && (x.man != 23'd0);
  endfunction

  // A NaN with the quiet bit clear is signalling.
  function automatic logic fp32_is_snan(input fp32_t x);
    return fp32_is_nan(x) && !x.man[22];
  endfunction

endpackage

// File: rtl/fpu_fminmax.sv
// Combinational FP32 min/max core for non-NaN operands; orders -0 below +0.
// NaN handling is the caller's responsibility.
module fpu_fminmax
  import fpu_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  input  logic  min0_max1,
  output fp32_t rd
);

  logic a_lt_b;

  // Sign-magnitude ordering: differing signs decide outright, so -0 < +0.
  always_comb begin
    if (a.sign != b.sign) begin
      a_lt_b = a.sign;
    end else if (a.sign) begin
      a_lt_b = {a.exp, a.man} > {b.exp, b.man};
    end else begin
      a_lt_b = {a.exp, a.man} < {b.exp, b.man};
    end
  end

  assign rd = (min0_max1 ^ a_lt_b) ? a : b;

endmodule

// File: rtl/fpu_fminmax_issue.sv
// Issue/result stage for fmin.s/fmax.s: operand FIFO, RISC-V NaN screening
// around the fpu_fminmax core, and a registered result for writeback.
module fpu_fminmax_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic             in_min0_max1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_fflags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    fp32_t            rs1;
    fp32_t            rs2;
    logic             min0_max1;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t              mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, enq, deq;

  op_t              head;
  fp32_t            core_rd;
  logic             rs1_nan, rs2_nan;
  logic [31:0]      head_result;
  fflags_t          head_fflags;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !flush && !rst;
  assign enq      = in_valid && in_ready;
  assign deq      = !empty && (!out_valid || out_ready);

  // NOTE: storage array has no reset; count/pointers alone define validity,
  // which keeps the array as plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, min0_max1: in_min0_max1, tag: in_tag};
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_fflags <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Payload only moves on a load, so it holds under back-pressure and idle.
      if (deq) begin
        out_valid  <= 1'b1;
        out_result <= head_result;
        out_tag    <= head.tag;
        out_fflags <= head_fflags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign head    = mem[rd_ptr];
  assign rs1_nan = fp32_is_nan(head.rs1);
  assign rs2_nan = fp32_is_nan(head.rs2);

  fpu_fminmax u_core (
    .a         (head.rs1),
    .b         (head.rs2),
    .min0_max1 (head.min0_max1),
    .rd        (core_rd)
  );

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    head_result = core_rd;
    head_fflags = '0;
    if (rs1_nan && rs2_nan) begin
      head_result = FP32_CANON_NAN;
    end else if (rs1_nan) begin
      head_result = head.rs2;
    end else if (rs2_nan) begin
      head_result = head.rs1;
    end
    head_fflags[FFLAG_NV] = fp32_is_snan(head.rs1) || fp32_is_snan(head.rs2);
  end

endmodule

// File: tb/tb_fpu_fminmax_issue.sv
// Scoreboard bench for fpu_fminmax_issue: directed cases, stall/flush/reset
// sequences and randomized traffic against a value-ordering reference model.
module tb_fpu_fminmax_issue;

  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, in_min0_max1;
  logic [31:0]      in_rs1, in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_fflags;

  fpu_fminmax_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_min0_max1 (in_min0_max1),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_fflags   (out_fflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [4:0]       fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic nx_rst, nx_flush, nx_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Total order on non-NaN values where -0 sits just below +0.
  function automatic longint order_key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? (-(2 * m) - 1) : (2 * m);
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic mx, input logic [TAG_W-1:0] t);
    exp_t   e;
    logic   an, bn, sig;
    longint ka, kb;
    an  = is_nan(a);
    bn  = is_nan(b);
    sig = (an && !a[22]) || (bn && !b[22]);
    ka  = order_key(a);
    kb  = order_key(b);
    if (an && bn)      e.res = 32'h7FC0_0000;
    else if (an)       e.res = b;
    else if (bn)       e.res = a;
    else if (mx)       e.res = (ka >= kb) ? a : b;
    else               e.res = (ka <= kb) ? a : b;
    e.tag = t;
    e.fl  = sig ? 5'b10000 : 5'b00000;
    return e;
  endfunction

  // One cycle of stimulus; expectation is queued if the op will be accepted.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic mx, input logic [TAG_W-1:0] t);
    @(negedge clk);
    rst          = nx_rst;
    flush        = nx_flush;
    out_ready    = nx_ready;
    in_valid     = v;
    in_rs1       = a;
    in_rs2       = b;
    in_min0_max1 = mx;
    in_tag       = t;
    #1;
    if (in_valid && in_ready) sb.push_back(model(a, b, mx, t));
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic mx, input logic [31:0] exp_res, input logic exp_nv);
    drive(1'b1, a, b, mx, 5'd7);
    idle();
    check({name, "_lat0"}, 64'(out_valid), 64'd0);
    idle();
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_res"}, 64'(out_result), 64'(exp_res));
    check({name, "_nv"}, 64'(out_fflags[4]), 64'(exp_nv));
  endtask

  task automatic fill_pipe();
    nx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, TAG_W'(i));
    idle();
  endtask

  // Monitor: consumes the output on each transfer, then honours flush/reset.
  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 64'(out_result), 64'(e.res));
        check("sb_tag", 64'(out_tag), 64'(e.tag));
        check("sb_fflags", 64'(out_fflags), 64'(e.fl));
      end
    end
    if (rst || flush) sb.delete();
  end

  logic [31:0] specials [12] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                                 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
                                 32'hFFC0_0005, 32'hFF80_0001, 32'h0000_0001, 32'h8000_0001};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 9) < 6) return specials[$urandom_range(0, 11)];
    return $urandom();
  endfunction

  logic [31:0]      held_res;
  logic [TAG_W-1:0] held_tag;
  logic [4:0]       held_fl;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_min0_max1 = 1'b0; in_tag = '0;
    nx_rst = 1'b1; nx_flush = 1'b0; nx_ready = 1'b1;

    idle();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    idle();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_payload", {27'(out_result), out_tag, out_fflags}, 64'd0);
    nx_rst = 1'b0;
    idle();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_one("fmin_1_2", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h3F80_0000, 1'b0);
    run_one("fmax_qnan", 32'h7FC0_0001, 32'hC040_0000, 1'b1, 32'hC040_0000, 1'b0);
    run_one("fmin_snan2", 32'h7F80_0001, 32'hFF80_0001, 1'b0, 32'h7FC0_0000, 1'b1);
    run_one("fmin_zero", 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0);
    run_one("fmax_zero", 32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);

    // Back-pressure: DEPTH+1 ops, output register plus full FIFO.
    nx_ready = 1'b0;
    drive(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd0);
    check("stall_rdy0", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b1, 5'd1);
    check("stall_rdy1", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h7F80_0001, 32'hBF80_0000, 1'b0, 5'd2);
    check("stall_rdy2", 64'(in_ready), 64'd1);
    check("stall_first_valid", 64'(out_valid), 64'd1);
    check("stall_first_tag", 64'(out_tag), 64'd0);
    held_res = out_result; held_tag = out_tag; held_fl = out_fflags;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("stall_full", 64'(in_ready), 64'd0);
      check("stall_hold", {27'(out_result ^ held_res), out_tag ^ held_tag, out_fflags ^ held_fl}, 64'd0);
    end
    nx_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Flush on a full pipe.
    fill_pipe();
    nx_flush = 1'b1;
    idle();
    check("flush_in_ready", 64'(in_ready), 64'd0);
    nx_flush = 1'b0; nx_ready = 1'b1;
    idle();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // Same with reset: payload also zeroed.
    fill_pipe();
    nx_rst = 1'b1;
    idle();
    nx_rst = 1'b0; nx_ready = 1'b1;
    idle();
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_payload", {27'(out_result), out_tag, out_fflags}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("rst2_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random back-pressure and occasional flush.
    for (int i = 0; i < 3000; i++) begin
      nx_ready = ($urandom_range(0, 9) < 7);
      nx_flush = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom()), TAG_W'($urandom()));
    end
    nx_flush = 1'b0; nx_ready = 1'b1;
    for (int i = 0; i < 10; i++) idle();
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
